// File: rtl/conv_ctrl_fsm_param_if.sv
// Control/handshake bundle between the conv control FSM (master) and the
// host/datapath side (slave). Select widths follow the FSM's beat counts.
interface conv_ctrl_fsm_param_if #(
   parameter int K_BEATS  = 12,
   parameter int I_BEATS  = 4,
   parameter int CC_BEATS = 6
);
   localparam int I_SEL_W = $clog2(I_BEATS);
   localparam int O_SEL_W = $clog2(CC_BEATS);

   logic               start;
   logic               abort;
   logic               running;
   logic               done;
   logic               con_valid;
   logic               con_ready;
   logic               out_ready;
   logic               output_valid;
   logic [31:0]        output_x;
   logic [31:0]        output_y;
   logic [31:0]        output_ch;
   logic [K_BEATS-1:0] kds_le_sel;
   logic [I_SEL_W-1:0] idss_le_sel;
   logic               idss_shift;
   logic [O_SEL_W-1:0] ods_sel_out;
   logic               ods_shift;
   logic               driving_cons;

   modport master (
      input  start, abort, con_valid, out_ready,
      output running, done, con_ready, output_valid, output_x, output_y, output_ch,
             kds_le_sel, idss_le_sel, idss_shift, ods_sel_out, ods_shift, driving_cons
   );

   modport slave (
      output start, abort, con_valid, out_ready,
      input  running, done, con_ready, output_valid, output_x, output_y, output_ch,
             kds_le_sel, idss_le_sel, idss_shift, ods_sel_out, ods_shift, driving_cons
   );
endinterface

// File: rtl/conv_ctrl_fsm_param.sv
// Control FSM for the conv accelerator: kernel load, IDSS row preload and per-pixel
// compute beats, walking x / y / output-channel-group loops with handshaked I/O.
module conv_ctrl_fsm_param #(
   parameter int FEATURE_MAP_WIDTH  = 1024,
   parameter int FEATURE_MAP_HEIGHT = 1024,
   parameter int OUTPUT_NB_CHANNELS = 64,
   parameter int CH_OUT_PAR         = 4,
   parameter int K_BEATS            = 12,
   parameter int K_LOADS            = 7,
   parameter int I_BEATS            = 4,
   parameter int I_ROWS             = 4,
   parameter int CC_BEATS           = 6
) (
   input  logic                  clk,
   input  logic                  arst_n_in,
   conv_ctrl_fsm_param_if.master bus
);
   localparam int I_SEL_W = $clog2(I_BEATS);
   localparam int O_SEL_W = $clog2(CC_BEATS);

   localparam logic [31:0] K_LAST    = 32'(K_BEATS - 1);
   localparam logic [31:0] KL_LAST   = 32'(K_LOADS - 1);
   localparam logic [31:0] I_LAST    = 32'(I_BEATS - 1);
   localparam logic [31:0] IR_LAST   = 32'(I_ROWS - 1);
   localparam logic [31:0] CC_LAST   = 32'(CC_BEATS - 1);
   localparam logic [31:0] I_BEATS32 = 32'(I_BEATS);
   localparam logic [31:0] H_BEAT    = 32'(CC_BEATS / 2);
   localparam logic [31:0] H_LAST    = 32'(CC_BEATS / 2 - 1);
   localparam logic [31:0] X_LAST    = 32'(FEATURE_MAP_WIDTH - 1);
   localparam logic [31:0] Y_LAST    = 32'(FEATURE_MAP_HEIGHT - 1);
   localparam logic [31:0] G_LAST    = 32'(OUTPUT_NB_CHANNELS / CH_OUT_PAR - 1);
   localparam logic [31:0] CH_STEP   = 32'(CH_OUT_PAR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_K,
      S_LOAD_I,
      S_I_SHIFT,
      S_COMPUTE,
      S_FLUSH
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] b_q, b_d;
   logic [31:0] kl_q, kl_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] x_q, x_d;
   logic [31:0] y_q, y_d;
   logic [31:0] grp_q, grp_d;
   logic [31:0] ch_q, ch_d;
   logic        ov_q, ov_d;
   logic [31:0] ox_q, ox_d;
   logic [31:0] oy_q, oy_d;
   logic [31:0] och_q, och_d;
   logic        done_q, done_d;

   logic               con_ready;
   logic [K_BEATS-1:0] kds_le_sel;
   logic [I_SEL_W-1:0] idss_le_sel;
   logic               idss_shift;
   logic [O_SEL_W-1:0] ods_sel_out;
   logic               ods_shift;
   logic               driving_cons;
   logic               advance;

   // NOTE: non-blocking assignments for all registered state so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state_q <= S_IDLE;
         b_q     <= '0;
         kl_q    <= '0;
         ir_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         grp_q   <= '0;
         ch_q    <= '0;
         ov_q    <= 1'b0;
         ox_q    <= '0;
         oy_q    <= '0;
         och_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         kl_q    <= kl_d;
         ir_q    <= ir_d;
         x_q     <= x_d;
         y_q     <= y_d;
         grp_q   <= grp_d;
         ch_q    <= ch_d;
         ov_q    <= ov_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         och_q   <= och_d;
         done_q  <= done_d;
      end
   end

   // NOTE: every variable gets a default before the case, so no path through
   // this block can infer a latch.
   always_comb begin
      state_d      = state_q;
      b_d          = b_q;
      kl_d         = kl_q;
      ir_d         = ir_q;
      x_d          = x_q;
      y_d          = y_q;
      grp_d        = grp_q;
      ch_d         = ch_q;
      ov_d         = ov_q;
      ox_d         = ox_q;
      oy_d         = oy_q;
      och_d        = och_q;
      done_d       = 1'b0;
      con_ready    = 1'b0;
      kds_le_sel   = '0;
      idss_le_sel  = '0;
      idss_shift   = 1'b0;
      ods_sel_out  = '1;
      ods_shift    = 1'b0;
      driving_cons = 1'b0;
      advance      = 1'b0;

      if (ov_q && bus.out_ready) begin
         ov_d = 1'b0;
      end

      // Abort beats every stall and transfer; strobes stay at their defaults.
      if (state_q != S_IDLE && bus.abort) begin
         state_d = S_IDLE;
         ov_d    = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_d = S_LOAD_K;
                  b_d     = '0;
                  kl_d    = '0;
                  ir_d    = '0;
                  x_d     = '0;
                  y_d     = '0;
                  grp_d   = '0;
                  ch_d    = '0;
               end
            end

            S_LOAD_K: begin
               con_ready  = 1'b1;
               kds_le_sel = K_BEATS'(1) << b_q;
               if (bus.con_valid) begin
                  if (b_q == K_LAST) begin
                     b_d  = '0;
                     kl_d = kl_q + 32'd1;
                     if (kl_q == KL_LAST) begin
                        state_d = S_LOAD_I;
                        ir_d    = '0;
                     end
                  end else begin
                     b_d = b_q + 32'd1;
                  end
               end
            end

            S_LOAD_I: begin
               con_ready   = 1'b1;
               idss_le_sel = b_q[I_SEL_W-1:0];
               if (bus.con_valid) begin
                  if (b_q == I_LAST) begin
                     b_d     = '0;
                     state_d = S_I_SHIFT;
                  end else begin
                     b_d = b_q + 32'd1;
                  end
               end
            end

            S_I_SHIFT: begin
               idss_shift = 1'b1;
               ir_d       = ir_q + 32'd1;
               state_d    = (ir_q == IR_LAST) ? S_COMPUTE : S_LOAD_I;
            end

            S_COMPUTE: begin
               ods_sel_out  = b_q[O_SEL_W-1:0];
               driving_cons = (b_q >= H_BEAT);
               if (b_q < I_BEATS32) begin
                  con_ready   = 1'b1;
                  idss_le_sel = b_q[I_SEL_W-1:0];
                  advance     = bus.con_valid;
               end else if (b_q == CC_LAST) begin
                  // An unaccepted previous result blocks the next capture.
                  advance = !(ov_q && !bus.out_ready);
               end else begin
                  advance = 1'b1;
               end

               if (advance && b_q == H_LAST) begin
                  idss_shift = 1'b1;
               end

               if (advance) begin
                  if (b_q != CC_LAST) begin
                     b_d = b_q + 32'd1;
                  end else begin
                     b_d        = '0;
                     idss_shift = 1'b1;
                     ods_shift  = 1'b1;
                     ov_d       = 1'b1;
                     ox_d       = x_q;
                     oy_d       = y_q;
                     och_d      = ch_q;
                     if (x_q != X_LAST) begin
                        x_d = x_q + 32'd1;
                     end else begin
                        x_d = '0;
                        if (y_q != Y_LAST) begin
                           y_d     = y_q + 32'd1;
                           ir_d    = '0;
                           state_d = S_LOAD_I;
                        end else begin
                           y_d = '0;
                           if (grp_q != G_LAST) begin
                              grp_d   = grp_q + 32'd1;
                              ch_d    = ch_q + CH_STEP;
                              kl_d    = '0;
                              state_d = S_LOAD_K;
                           end else begin
                              state_d = S_FLUSH;
                           end
                        end
                     end
                  end
               end
            end

            S_FLUSH: begin
               if (!ov_q || bus.out_ready) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign bus.running      = (state_q != S_IDLE);
   assign bus.done         = done_q;
   assign bus.con_ready    = con_ready;
   assign bus.output_valid = ov_q;
   assign bus.output_x     = ox_q;
   assign bus.output_y     = oy_q;
   assign bus.output_ch    = och_q;
   assign bus.kds_le_sel   = kds_le_sel;
   assign bus.idss_le_sel  = idss_le_sel;
   assign bus.idss_shift   = idss_shift;
   assign bus.ods_sel_out  = ods_sel_out;
   assign bus.ods_shift    = ods_shift;
   assign bus.driving_cons = driving_cons;

endmodule

// File: tb/tb_conv_ctrl_fsm_param.sv
// Directed bench for conv_ctrl_fsm_param on the small W=2,H=2 configuration;
// a coordinate scoreboard is filled at each start and drained on output accepts.
module tb_conv_ctrl_fsm_param;
   localparam int W      = 2;
   localparam int H      = 2;
   localparam int OUT_CH = 4;
   localparam int PAR    = 2;
   localparam int KB     = 3;
   localparam int KL     = 2;
   localparam int IB     = 2;
   localparam int IR     = 2;
   localparam int CC     = 4;
   localparam int BUDGET = 1000;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] ch;
   } coord_t;

   logic clk       = 1'b0;
   logic arst_n_in = 1'b0;
   always #5 clk = ~clk;

   conv_ctrl_fsm_param_if #(.K_BEATS(KB), .I_BEATS(IB), .CC_BEATS(CC)) bus ();

   conv_ctrl_fsm_param #(
      .FEATURE_MAP_WIDTH (W),
      .FEATURE_MAP_HEIGHT(H),
      .OUTPUT_NB_CHANNELS(OUT_CH),
      .CH_OUT_PAR        (PAR),
      .K_BEATS           (KB),
      .K_LOADS           (KL),
      .I_BEATS           (IB),
      .I_ROWS            (IR),
      .CC_BEATS          (CC)
   ) dut (
      .clk      (clk),
      .arst_n_in(arst_n_in),
      .bus      (bus)
   );

   int     n_checks  = 0;
   int     n_fail    = 0;
   int     done_cnt  = 0;
   int     out_cnt   = 0;
   int     kds_cnt   = 0;
   bit     toggle_cv = 1'b0;
   coord_t sb_q[$];

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample just before the edge, then step past it.
   task automatic tick();
      coord_t        got;
      coord_t        exp_c;
      logic [KB-1:0] kds_exp;
      #1;
      if (bus.output_valid && bus.out_ready) begin
         check("sb_underflow", 96'(sb_q.size() > 0), 96'd1);
         if (sb_q.size() > 0) begin
            exp_c = sb_q.pop_front();
            got   = {bus.output_x, bus.output_y, bus.output_ch};
            check("sb_coord", got, exp_c);
            out_cnt++;
         end
      end
      if (bus.kds_le_sel != '0) begin
         kds_exp                = '0;
         kds_exp[kds_cnt % KB]  = 1'b1;
         check("kds_onehot", 96'(bus.kds_le_sel), 96'(kds_exp));
         if (bus.con_valid && bus.con_ready) kds_cnt++;
      end
      if (bus.done) done_cnt++;
      @(posedge clk);
      #1;
      if (toggle_cv) bus.con_valid = ~bus.con_valid;
   endtask

   task automatic start_run();
      kds_cnt = 0;
      out_cnt = 0;
      for (int g = 0; g < OUT_CH / PAR; g++)
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
               sb_q.push_back(coord_t'({32'(x), 32'(y), 32'(g * PAR)}));
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic run_to_done(input string tag);
      int base;
      int n;
      base = done_cnt;
      n    = 0;
      while (done_cnt == base && n < BUDGET) begin
         tick();
         n++;
      end
      check({tag, "_done_once"}, 96'(done_cnt - base), 96'd1);
      check({tag, "_outputs"}, 96'(out_cnt), 96'd8);
      check({tag, "_sb_empty"}, 96'(sb_q.size()), 96'd0);
      check({tag, "_running_low"}, 96'(bus.running), 96'd0);
      check({tag, "_done_width"}, 96'(bus.done), 96'd0);
   endtask

   task automatic wait_output_valid(input string tag);
      int n;
      n = 0;
      while (!bus.output_valid && n < BUDGET) begin
         tick();
         n++;
      end
      check({tag, "_first_valid"}, 96'(bus.output_valid), 96'd1);
   endtask

   initial begin
      int base;
      int n;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.con_valid = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      check("rst_running", 96'(bus.running), 96'd0);
      check("rst_done", 96'(bus.done), 96'd0);
      check("rst_con_ready", 96'(bus.con_ready), 96'd0);
      check("rst_output_valid", 96'(bus.output_valid), 96'd0);
      check("rst_strobes", 96'({bus.kds_le_sel, bus.idss_le_sel, bus.idss_shift,
                                bus.ods_shift, bus.driving_cons}), 96'd0);
      check("rst_ods_sel", 96'(bus.ods_sel_out), 96'd3);
      check("rst_coords", 96'({bus.output_x, bus.output_y, bus.output_ch}), 96'd0);
      #2 arst_n_in = 1'b1;
      tick();

      // 1: full run, always valid/ready.
      bus.con_valid = 1'b1;
      bus.out_ready = 1'b1;
      start_run();
      run_to_done("s1");
      check("s1_kds_xfers", 96'(kds_cnt), 96'd12);
      tick();
      check("s1_idle_after", 96'(bus.running), 96'd0);

      // 2: con_valid alternating; KDS select must only step on a transfer.
      toggle_cv = 1'b1;
      start_run();
      run_to_done("s2");
      check("s2_kds_xfers", 96'(kds_cnt), 96'd12);
      toggle_cv     = 1'b0;
      bus.con_valid = 1'b1;
      tick();

      // 3: hold off the first output for ten cycles.
      bus.out_ready = 1'b0;
      start_run();
      wait_output_valid("s3");
      for (int i = 0; i < 10; i++) begin
         check("s3_hold_valid", 96'(bus.output_valid), 96'd1);
         check("s3_hold_coord", 96'({bus.output_x, bus.output_y, bus.output_ch}), 96'd0);
         if (i >= 3) begin
            check("s3_stall_sel", 96'(bus.ods_sel_out), 96'd3);
            check("s3_stall_strobes", 96'({bus.ods_shift, bus.idss_shift, bus.con_ready}), 96'd0);
         end
         tick();
      end
      bus.out_ready = 1'b1;
      run_to_done("s3");

      // 4: abort in COMPUTE of pixel (1,0) with the first output still pending.
      start_run();
      wait_output_valid("s4");
      bus.out_ready = 1'b0;
      bus.abort     = 1'b1;
      #1;
      check("s4_abort_ready", 96'(bus.con_ready), 96'd0);
      check("s4_abort_strobes", 96'({bus.kds_le_sel, bus.idss_shift, bus.ods_shift}), 96'd0);
      base = done_cnt;
      tick();
      check("s4_abort_idle", 96'(bus.running), 96'd0);
      check("s4_abort_ov", 96'(bus.output_valid), 96'd0);
      bus.abort     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      check("s4_no_done", 96'(done_cnt - base), 96'd0);
      check("s4_stays_idle", 96'(bus.running), 96'd0);
      sb_q.delete();
      start_run();
      run_to_done("s4_replay");

      // 5: asynchronous reset while preloading IDSS rows.
      start_run();
      n = 0;
      while (!(bus.con_ready && bus.kds_le_sel == '0 && bus.ods_sel_out == 2'd3) && n < BUDGET) begin
         tick();
         n++;
      end
      check("s5_in_load_i", 96'(bus.con_ready && bus.kds_le_sel == '0), 96'd1);
      bus.con_valid = 1'b0;
      #1 arst_n_in = 1'b0;
      #1;
      check("s5_rst_running", 96'(bus.running), 96'd0);
      check("s5_rst_ready", 96'(bus.con_ready), 96'd0);
      check("s5_rst_ov", 96'(bus.output_valid), 96'd0);
      check("s5_rst_ods_sel", 96'(bus.ods_sel_out), 96'd3);
      check("s5_rst_coords", 96'({bus.output_x, bus.output_y, bus.output_ch}), 96'd0);
      check("s5_rst_strobes", 96'({bus.done, bus.idss_le_sel, bus.idss_shift, bus.ods_shift}), 96'd0);
      #1 arst_n_in = 1'b1;
      sb_q.delete();
      bus.con_valid = 1'b1;
      tick();
      check("s5_after_rst_idle", 96'(bus.running), 96'd0);

      // 6: start pulses during a run must not disturb it.
      start_run();
      base = done_cnt;
      n    = 0;
      while (done_cnt == base && n < BUDGET) begin
         bus.start = (n == 5 || n == 22 || n == 45);
         tick();
         n++;
      end
      bus.start = 1'b0;
      check("s6_done_once", 96'(done_cnt - base), 96'd1);
      check("s6_outputs", 96'(out_cnt), 96'd8);
      check("s6_sb_empty", 96'(sb_q.size()), 96'd0);
      repeat (2) tick();
      check("s6_idle_after", 96'(bus.running), 96'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
